// File: rtl/fir_tap_loader.sv
// Byte-stream feeder for the 4-tap FIR core: assembles words and routes them
// either into the sample delay line or round-robin into the coefficient bank.
module fir_tap_loader #(
  parameter int NUM_COEFF   = 4,
  parameter int NUMBER_SIZE = 16,
  parameter int IN_WIDTH    = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [IN_WIDTH-1:0]              in_data,
  input  logic                             in_valid,
  input  logic                             in_is_coeff,
  output logic                             in_ready,
  output logic [NUM_COEFF*NUMBER_SIZE-1:0] x_ns,
  output logic [NUMBER_SIZE*NUM_COEFF-1:0] coeffs,
  output logic                             sample_strobe,
  output logic                             taps_full,
  output logic                             coeff_loaded
);

  localparam int BEATS = NUMBER_SIZE / IN_WIDTH;
  localparam int BCW   = $clog2(BEATS) + 1;
  localparam int CIW   = $clog2(NUM_COEFF) + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACC    = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
  localparam logic [CIW-1:0] LAST_IDX  = CIW'(NUM_COEFF - 1);
  localparam logic [CIW-1:0] FILL_MAX  = CIW'(NUM_COEFF);

  logic [1:0]                       state_r;
  logic [BCW-1:0]                   beat_cnt_r;
  logic [CIW-1:0]                   coeff_idx_r;
  logic [CIW-1:0]                   fill_r;
  logic                             mode_r;
  logic [NUMBER_SIZE-1:0]           word_r;
  logic [NUM_COEFF*NUMBER_SIZE-1:0] x_r;
  logic [NUMBER_SIZE*NUM_COEFF-1:0] coeffs_r;
  logic                             strobe_r;
  logic                             taps_full_r;
  logic                             loaded_r;
  logic                             xfer_s;

  // The COMMIT state is a registered state, so ready is glitch-free.
  assign in_ready      = (state_r != COMMIT);
  assign xfer_s        = in_valid & in_ready;
  assign x_ns          = x_r;
  assign coeffs        = coeffs_r;
  assign sample_strobe = strobe_r;
  assign taps_full     = taps_full_r;
  assign coeff_loaded  = loaded_r;

  // Word assembly FSM plus commit of finished words to their destination.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      beat_cnt_r  <= '0;
      coeff_idx_r <= '0;
      fill_r      <= '0;
      mode_r      <= 1'b0;
      word_r      <= '0;
      x_r         <= '0;
      coeffs_r    <= '0;
      strobe_r    <= 1'b0;
      taps_full_r <= 1'b0;
      loaded_r    <= 1'b0;
    end else begin
      strobe_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (xfer_s) begin
            word_r[IN_WIDTH-1:0] <= in_data;
            mode_r               <= in_is_coeff;
            if (BEATS == 1) begin
              state_r <= COMMIT;
            end else begin
              state_r    <= ACC;
              beat_cnt_r <= BCW'(1);
            end
          end
        end
        ACC: begin
          if (xfer_s) begin
            for (int b = 1; b < BEATS; b++) begin
              if (beat_cnt_r == BCW'(b)) begin
                word_r[b*IN_WIDTH +: IN_WIDTH] <= in_data;
              end
            end
            if (beat_cnt_r == LAST_BEAT) begin
              state_r    <= COMMIT;
              beat_cnt_r <= '0;
            end else begin
              beat_cnt_r <= beat_cnt_r + BCW'(1);
            end
          end
        end
        COMMIT: begin
          state_r <= IDLE;
          if (mode_r) begin
            for (int k = 0; k < NUM_COEFF; k++) begin
              if (coeff_idx_r == CIW'(k)) begin
                coeffs_r[k*NUMBER_SIZE +: NUMBER_SIZE] <= word_r;
              end
            end
            if (coeff_idx_r == LAST_IDX) begin
              coeff_idx_r <= '0;
              loaded_r    <= 1'b1;
            end else begin
              coeff_idx_r <= coeff_idx_r + CIW'(1);
            end
          end else begin
            x_r      <= {x_r[(NUM_COEFF-1)*NUMBER_SIZE-1:0], word_r};
            strobe_r <= 1'b1;
            if (fill_r != FILL_MAX) begin
              fill_r <= fill_r + CIW'(1);
            end
            // Sticky: set by the commit that brings the fill count to full.
            if (fill_r >= LAST_IDX) begin
              taps_full_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          beat_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_loader.sv
// Self-checking bench for fir_tap_loader: directed scenarios plus random traffic,
// each cycle compared against a word-level reference model.
module tb_fir_tap_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_is_coeff;
  logic        in_ready;
  logic [63:0] x_ns;
  logic [63:0] coeffs;
  logic        sample_strobe;
  logic        taps_full;
  logic        coeff_loaded;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [15:0] mx [4];
  logic [15:0] mc [4];
  logic [7:0]  mb [2];
  int          m_nbeats;
  int          m_cidx;
  int          m_fill;
  logic        m_mode;
  logic        m_pend;
  logic        m_strobe;
  logic        m_loaded;

  int strobe_cnt;
  int notready_cnt;

  fir_tap_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_is_coeff(in_is_coeff), .in_ready(in_ready), .x_ns(x_ns),
    .coeffs(coeffs), .sample_strobe(sample_strobe), .taps_full(taps_full),
    .coeff_loaded(coeff_loaded)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mx[i] = 16'h0000;
      mc[i] = 16'h0000;
    end
    m_nbeats = 0; m_cidx = 0; m_fill = 0;
    m_mode = 1'b0; m_pend = 1'b0; m_strobe = 1'b0; m_loaded = 1'b0;
  endtask

  // One clock edge of the word-level model: a finished word spends one cycle
  // pending (no beat accepted), then lands in its destination.
  task automatic model_edge(input logic v, input logic [7:0] d, input logic c);
    m_strobe = 1'b0;
    if (m_pend) begin
      if (m_mode) begin
        mc[m_cidx] = {mb[1], mb[0]};
        m_cidx = (m_cidx + 1) % 4;
        if (m_cidx == 0) m_loaded = 1'b1;
      end else begin
        for (int i = 3; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = {mb[1], mb[0]};
        m_strobe = 1'b1;
        if (m_fill < 4) m_fill++;
      end
      m_pend = 1'b0;
    end else if (v) begin
      if (m_nbeats == 0) m_mode = c;
      mb[m_nbeats] = d;
      m_nbeats++;
      if (m_nbeats == 2) begin
        m_pend = 1'b1;
        m_nbeats = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".ready"},  {63'd0, in_ready},      {63'd0, ~m_pend});
    check_eq({tag, ".x_ns"},   x_ns,                   {mx[3], mx[2], mx[1], mx[0]});
    check_eq({tag, ".coeffs"}, coeffs,                 {mc[3], mc[2], mc[1], mc[0]});
    check_eq({tag, ".strobe"}, {63'd0, sample_strobe}, {63'd0, m_strobe});
    check_eq({tag, ".full"},   {63'd0, taps_full},     {63'd0, (m_fill == 4)});
    check_eq({tag, ".loaded"}, {63'd0, coeff_loaded},  {63'd0, m_loaded});
  endtask

  // Drive one cycle from a negedge; returns whether the beat was taken.
  task automatic step(input string tag, input logic v, input logic [7:0] d,
                      input logic c, output logic acc);
    in_valid = v; in_data = d; in_is_coeff = c;
    acc = v & ~m_pend;
    @(posedge clk);
    model_edge(v, d, c);
    @(negedge clk);
    if (sample_strobe) strobe_cnt++;
    if (!in_ready) notready_cnt++;
    check_all(tag);
  endtask

  task automatic send_beat(input string tag, input logic [7:0] d, input logic c);
    logic acc;
    int   tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 8) begin
      step(tag, 1'b1, d, c, acc);
      tries++;
    end
    if (!acc) check_eq({tag, ".timeout"}, 64'd1, 64'd0);
  endtask

  task automatic send_word(input string tag, input logic [15:0] w, input logic c);
    send_beat(tag, w[7:0], c);
    send_beat(tag, w[15:8], c);
  endtask

  task automatic idle(input string tag, input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(tag, 1'b0, 8'h00, 1'b0, acc);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic acc;
    in_valid = 1'b0; in_data = 8'h00; in_is_coeff = 1'b0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check_all("reset0");
    rst = 1'b0;

    // Reset mid-word discards the partial beat
    send_beat("t1", 8'hAA, 1'b0);
    do_reset("t1rst");
    check_eq("t1.x_zero", x_ns, 64'd0);
    send_word("t1", 16'h1234, 1'b0);
    idle("t1", 1);
    check_eq("t1.fresh", x_ns, 64'h0000_0000_0000_1234);

    // Coefficient load
    do_reset("t2rst");
    for (int i = 1; i <= 4; i++) begin
      send_word("t2", 16'(i), 1'b1);
      if (i == 3) begin
        idle("t2", 1);
        check_eq("t2.not_loaded", {63'd0, coeff_loaded}, 64'd0);
      end
    end
    idle("t2", 1);
    check_eq("t2.coeffs", coeffs, 64'h0004_0003_0002_0001);
    check_eq("t2.loaded", {63'd0, coeff_loaded}, 64'd1);

    // Sample fill and drop of the oldest sample
    do_reset("t3rst");
    for (int i = 1; i <= 4; i++) send_word("t3", 16'(i * 16), 1'b0);
    idle("t3", 1);
    check_eq("t3.x_ns", x_ns, 64'h0010_0020_0030_0040);
    check_eq("t3.full", {63'd0, taps_full}, 64'd1);
    send_word("t3", 16'h0050, 1'b0);
    idle("t3", 1);
    check_eq("t3.shift", x_ns, 64'h0020_0030_0040_0050);

    // Continuous valid: 4 words in 12 cycles
    strobe_cnt = 0; notready_cnt = 0;
    for (int i = 0; i < 12; i++) step("t4", 1'b1, 8'($urandom), 1'b0, acc);
    check_eq("t4.strobes", 64'(strobe_cnt), 64'd4);
    check_eq("t4.notready", 64'(notready_cnt), 64'd4);

    // Mode latched on first beat only
    send_beat("t5", 8'h5A, 1'b0);
    send_beat("t5", 8'hC3, 1'b1);
    idle("t5", 1);
    check_eq("t5.x0", {48'd0, x_ns[15:0]}, 64'h0000_0000_0000_C35A);
    check_eq("t5.coeffs", coeffs, 64'd0);

    // Interleaved sample, coeff, sample
    do_reset("t6rst");
    strobe_cnt = 0;
    send_word("t6", 16'h1111, 1'b0);
    send_word("t6", 16'h2222, 1'b1);
    send_word("t6", 16'h3333, 1'b0);
    idle("t6", 2);
    check_eq("t6.strobes", 64'(strobe_cnt), 64'd2);
    check_eq("t6.x_ns", x_ns, 64'h0000_0000_1111_3333);
    check_eq("t6.coeffs", coeffs, 64'h0000_0000_0000_2222);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(0, 3) != 0), 8'($urandom),
           1'($urandom_range(0, 1)), acc);
      if (i == 200) do_reset("rndrst");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
